nxm_scan_ctrl: RTL and testbench

- Sequences readout of an N×M microbolometer pixel matrix.
- For each pixel it: selects the pixel, drives the settle-timer (the down-counter divider with `h_i`/`kmax_i` inputs and a terminal-count tick), waits for the tick, triggers one ADC conversion, and presents the result with its row/column address.
- Sits between the top-level start/abort control and the row/column mux, settle timer and ADC interface.

---
 rtl/nxm_scan_ctrl_pkg.sv | 17 +
 rtl/nxm_addr_cnt.sv | 58 +++++
 rtl/nxm_scan_ctrl.sv | 145 ++++++++++++++
 tb/tb_nxm_scan_ctrl.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/nxm_scan_ctrl_pkg.sv
// Shared types and defaults for the N x M pixel scan controller.
package nxm_scan_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SELECT,
    ST_SETTLE,
    ST_CONV,
    ST_WAIT,
    ST_NEXT
  } state_e;

  localparam int DEF_DATA_W = 12;
  // ADC-done timeout counter width; the timeout is reached when it would hit all-ones.
  localparam int DEF_TO_W   = 10;

endpackage : nxm_scan_ctrl_pkg

// File: rtl/nxm_addr_cnt.sv
// Row/column raster counter with latched limits and an end-of-matrix flag.
module nxm_addr_cnt #(
  parameter int RowW = 4,
  parameter int ColW = 4
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            load_i,
  input  logic            inc_i,
  input  logic [RowW-1:0] nrows_i,
  input  logic [ColW-1:0] ncols_i,
  output logic [RowW-1:0] row_o,
  output logic [ColW-1:0] col_o,
  output logic            last_o
);

  logic [RowW-1:0] nrows_q, nrows_d, row_q, row_d;
  logic [ColW-1:0] ncols_q, ncols_d, col_q, col_d;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      nrows_q <= '0;
      ncols_q <= '0;
      row_q   <= '0;
      col_q   <= '0;
    end else begin
      nrows_q <= nrows_d;
      ncols_q <= ncols_d;
      row_q   <= row_d;
      col_q   <= col_d;
    end
  end

  always_comb begin
    nrows_d = nrows_q;
    ncols_d = ncols_q;
    row_d   = row_q;
    col_d   = col_q;
    if (load_i) begin
      nrows_d = nrows_i;
      ncols_d = ncols_i;
      row_d   = '0;
      col_d   = '0;
    end else if (inc_i) begin
      if (col_q == ncols_q) begin
        col_d = '0;
        row_d = row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  assign row_o  = row_q;
  assign col_o  = col_q;
  assign last_o = (row_q == nrows_q) && (col_q == ncols_q);

endmodule : nxm_addr_cnt

// File: rtl/nxm_scan_ctrl.sv
// Frame scan sequencer: select pixel, settle via external timer, convert, present sample.
module nxm_scan_ctrl
  import nxm_scan_ctrl_pkg::*;
#(
  parameter int RowW  = 4,
  parameter int ColW  = 4,
  parameter int Width = 8,
  parameter int DataW = DEF_DATA_W,
  parameter int ToW   = DEF_TO_W
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic [RowW-1:0]  nrows_i,
  input  logic [ColW-1:0]  ncols_i,
  input  logic [Width-1:0] ksettle_i,
  input  logic             tick_i,
  output logic             h_o,
  output logic [Width-1:0] kmax_o,
  output logic [RowW-1:0]  row_o,
  output logic [ColW-1:0]  col_o,
  output logic             adc_start_o,
  input  logic             adc_done_i,
  input  logic [DataW-1:0] adc_data_i,
  output logic [DataW-1:0] data_o,
  output logic             data_valid_o,
  output logic             err_o,
  output logic             busy_o,
  output logic             done_o
);

  // Counter value whose increment reaches all-ones: WAIT lasts 2**ToW-1 cycles at most.
  localparam logic [ToW-1:0] ToLast = {{(ToW-1){1'b1}}, 1'b0};

  state_e           state_q, state_d;
  logic [Width-1:0] kmax_q, kmax_d;
  logic [ToW-1:0]   to_q, to_d;
  logic [DataW-1:0] data_q, data_d;
  logic             err_q, err_d;
  logic             valid_q, valid_d;
  logic             done_q, done_d;
  logic             addr_load, addr_inc, addr_last;

  nxm_addr_cnt #(
    .RowW (RowW),
    .ColW (ColW)
  ) u_addr (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .load_i  (addr_load),
    .inc_i   (addr_inc),
    .nrows_i (nrows_i),
    .ncols_i (ncols_i),
    .row_o   (row_o),
    .col_o   (col_o),
    .last_o  (addr_last)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= ST_IDLE;
      kmax_q  <= Width'(1);
      to_q    <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      kmax_q  <= kmax_d;
      to_q    <= to_d;
      data_q  <= data_d;
      err_q   <= err_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    kmax_d      = kmax_q;
    to_d        = to_q;
    data_d      = data_q;
    err_d       = err_q;
    valid_d     = 1'b0;
    done_d      = 1'b0;
    addr_load   = 1'b0;
    addr_inc    = 1'b0;
    h_o         = 1'b0;
    adc_start_o = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          addr_load = 1'b1;
          err_d     = 1'b0;
          // A zero reload would stall the timer; treat it as the shortest settle.
          kmax_d    = (ksettle_i == '0) ? Width'(1) : ksettle_i;
          state_d   = ST_SELECT;
        end
      end
      ST_SELECT: state_d = ST_SETTLE;
      ST_SETTLE: begin
        h_o = 1'b1;
        if (tick_i) state_d = ST_CONV;
      end
      ST_CONV: begin
        adc_start_o = 1'b1;
        to_d        = '0;
        state_d     = ST_WAIT;
      end
      ST_WAIT: begin
        to_d = to_q + 1'b1;
        if (adc_done_i) begin
          data_d  = adc_data_i;
          valid_d = 1'b1;
          state_d = ST_NEXT;
        end else if (to_q == ToLast) begin
          err_d   = 1'b1;
          data_d  = '1;
          valid_d = 1'b1;
          state_d = ST_NEXT;
        end
      end
      ST_NEXT: begin
        if (abort_i || addr_last) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          addr_inc = 1'b1;
          state_d  = ST_SELECT;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign kmax_o       = kmax_q;
  assign data_o       = data_q;
  assign data_valid_o = valid_q;
  assign err_o        = err_q;
  assign done_o       = done_q;
  assign busy_o       = (state_q != ST_IDLE);

endmodule : nxm_scan_ctrl

// File: tb/tb_nxm_scan_ctrl.sv
// Frame-level bench: timer and ADC models around the scan controller, checked per pixel.
module tb_nxm_scan_ctrl;

  typedef struct {
    int nr;
    int nc;
    int k;
    bit sil;
    int sr;
    int sc;
    int abort_pix;
    bit bstart;
    int exp_kmax;
    int exp_npix;
  } vec_t;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        start_i = 1'b0;
  logic        abort_i = 1'b0;
  logic [3:0]  nrows_i = '0;
  logic [3:0]  ncols_i = '0;
  logic [7:0]  ksettle_i = '0;
  logic        tick_i;
  logic        h_o;
  logic [7:0]  kmax_o;
  logic [3:0]  row_o;
  logic [3:0]  col_o;
  logic        adc_start_o;
  logic        adc_done_i;
  logic [11:0] adc_data_i;
  logic [11:0] data_o;
  logic        data_valid_o;
  logic        err_o;
  logic        busy_o;
  logic        done_o;

  int checks = 0;
  int failures = 0;

  nxm_scan_ctrl dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .start_i      (start_i),
    .abort_i      (abort_i),
    .nrows_i      (nrows_i),
    .ncols_i      (ncols_i),
    .ksettle_i    (ksettle_i),
    .tick_i       (tick_i),
    .h_o          (h_o),
    .kmax_o       (kmax_o),
    .row_o        (row_o),
    .col_o        (col_o),
    .adc_start_o  (adc_start_o),
    .adc_done_i   (adc_done_i),
    .adc_data_i   (adc_data_i),
    .data_o       (data_o),
    .data_valid_o (data_valid_o),
    .err_o        (err_o),
    .busy_o       (busy_o),
    .done_o       (done_o)
  );

  always #5 clk_i = ~clk_i;

  // Settle timer: parked at kmax while disabled, down-counts while enabled, ticks at zero.
  logic [7:0] tcnt;
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) tcnt <= '0;
    else if (!h_o || tcnt == 8'd0) tcnt <= kmax_o;
    else tcnt <= tcnt - 8'd1;
  end
  assign tick_i = h_o && (tcnt == 8'd0);

  // ADC: done strobe 5 cycles after the start, data = {row,col}; can stay silent for one pixel.
  bit          sil_en = 1'b0;
  int          sil_r = 0, sil_c = 0;
  int          pend = 0;
  logic        adc_done_m = 1'b0;
  logic [11:0] adc_data_m = '0;
  logic        done_f = 1'b0;
  logic [11:0] data_f = '0;
  assign adc_done_i = adc_done_m | done_f;
  assign adc_data_i = done_f ? data_f : adc_data_m;

  always @(negedge clk_i) begin
    if (!rst_i) begin
      pend = 0;
      adc_done_m = 1'b0;
    end else begin
      adc_done_m = 1'b0;
      if (adc_start_o) begin
        if (!(sil_en && int'(row_o) == sil_r && int'(col_o) == sil_c)) begin
          pend = 5;
          adc_data_m = {4'b0, row_o, col_o};
        end
      end else if (pend > 0) begin
        pend--;
        if (pend == 0) adc_done_m = 1'b1;
      end
    end
  end

  // Monitor: record each presented sample, settle run length, conversion latency, done pulses.
  int cyc = 0, hrun = 0, st_cyc = 0, v_cyc = 0, done_cnt = 0, done_cyc = 0;
  int v_row[$], v_col[$], v_data[$], v_err[$], lat_q[$], settle_q[$];

  always @(negedge clk_i) begin
    cyc++;
    if (!rst_i) begin
      hrun = 0;
    end else begin
      if (h_o) hrun++;
      else if (hrun > 0) begin
        settle_q.push_back(hrun);
        hrun = 0;
      end
      if (adc_start_o) st_cyc = cyc;
      if (data_valid_o) begin
        v_row.push_back(int'(row_o));
        v_col.push_back(int'(col_o));
        v_data.push_back(int'(data_o));
        v_err.push_back(int'(err_o));
        lat_q.push_back(cyc - st_cyc);
        v_cyc = cyc;
      end
      if (done_o) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic clear_mon();
    v_row.delete(); v_col.delete(); v_data.delete(); v_err.delete();
    lat_q.delete(); settle_q.delete();
    done_cnt = 0;
  endtask

  task automatic run_frame(input vec_t v);
    int  kexp, silidx, n, r, c;
    bit  bsent, silent;
    clear_mon();
    bsent = 1'b0;
    @(negedge clk_i);
    nrows_i = 4'(v.nr); ncols_i = 4'(v.nc); ksettle_i = 8'(v.k);
    sil_en = v.sil; sil_r = v.sr; sil_c = v.sc;
    start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    for (n = 0; n < 3000 && done_cnt == 0; n++) begin
      @(negedge clk_i);
      if (v.bstart && h_o && !bsent) begin
        start_i = 1'b1; nrows_i = 4'd3; ncols_i = 4'd3; ksettle_i = 8'd9;
        bsent = 1'b1;
      end else begin
        start_i = 1'b0;
      end
      if (v.abort_pix >= 0 && h_o && int'(row_o) * (v.nc + 1) + int'(col_o) == v.abort_pix)
        abort_i = 1'b1;
    end
    start_i = 1'b0;
    repeat (3) @(negedge clk_i);
    abort_i = 1'b0;
    sil_en = 1'b0;
    if (done_cnt == 0) chk("frame_done_bound", 0, 1);

    kexp   = (v.k == 0) ? 1 : v.k;
    silidx = v.sr * (v.nc + 1) + v.sc;
    chk("valid_count", v_row.size(), v.exp_npix);
    chk("settle_count", settle_q.size(), v.exp_npix);
    for (int i = 0; i < v_row.size() && i < settle_q.size() && i < v.exp_npix; i++) begin
      r = i / (v.nc + 1);
      c = i % (v.nc + 1);
      silent = v.sil && r == v.sr && c == v.sc;
      chk("pix_row", v_row[i], r);
      chk("pix_col", v_col[i], c);
      chk("pix_data", v_data[i], silent ? 32'hFFF : r * 16 + c);
      chk("pix_err", v_err[i], (v.sil && i >= silidx) ? 1 : 0);
      chk("pix_latency", lat_q[i], silent ? 1024 : 6);
      chk("settle_len", settle_q[i], kexp + 1);
    end
    chk("done_pulses", done_cnt, 1);
    chk("done_after_last", done_cyc, v_cyc + 1);
    chk("idle_busy", busy_o, 0);
    chk("frame_kmax", kmax_o, v.exp_kmax);
    chk("err_end", err_o, (v.sil && v.exp_npix > silidx) ? 1 : 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  vec_t tbl[6];
  vec_t rv;
  int   w;

  initial begin
    //        nr nc k  sil sr sc abort bst kmax npix
    tbl[0] = '{1, 2, 4, 0, 0, 0, -1, 0, 4, 6};   // 2x3 frame
    tbl[1] = '{0, 1, 0, 0, 0, 0, -1, 0, 1, 2};   // ksettle 0 -> 1
    tbl[2] = '{1, 2, 2, 1, 0, 1, -1, 0, 2, 6};   // ADC silent at (0,1)
    tbl[3] = '{0, 0, 3, 0, 0, 0, -1, 0, 3, 1};   // 1x1, new start clears err
    tbl[4] = '{1, 2, 4, 0, 0, 0,  1, 0, 4, 2};   // abort in SETTLE of (0,1)
    tbl[5] = '{0, 2, 1, 0, 0, 0, -1, 1, 1, 3};   // start while busy ignored

    #12;
    chk("rst_kmax", kmax_o, 1);
    chk("rst_outs", {h_o, row_o, col_o, adc_start_o, data_o, data_valid_o, err_o, busy_o, done_o}, 0);
    @(negedge clk_i);
    rst_i = 1'b1;
    repeat (2) @(negedge clk_i);

    foreach (tbl[i]) run_frame(tbl[i]);

    for (int i = 0; i < 4; i++) begin
      rv = '{0, 0, 0, 0, 0, 0, -1, 0, 0, 0};
      rv.nr = $urandom_range(0, 2);
      rv.nc = $urandom_range(0, 3);
      rv.k  = $urandom_range(0, 6);
      rv.exp_kmax = (rv.k == 0) ? 1 : rv.k;
      rv.exp_npix = (rv.nr + 1) * (rv.nc + 1);
      run_frame(rv);
    end

    // Reset asserted mid-conversion: outputs drop without waiting for a clock edge.
    @(negedge clk_i);
    nrows_i = 4'd2; ncols_i = 4'd2; ksettle_i = 8'd5;
    start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    for (w = 0; w < 200 && !adc_start_o; w++) @(negedge clk_i);
    chk("rst_reach_conv", adc_start_o, 1);
    @(negedge clk_i);
    #2;
    rst_i = 1'b0;
    #1;
    chk("async_rst_kmax", kmax_o, 1);
    chk("async_rst_outs", {h_o, row_o, col_o, adc_start_o, data_o, data_valid_o, err_o, busy_o, done_o}, 0);
    repeat (2) @(negedge clk_i);
    rst_i = 1'b1;
    run_frame('{0, 0, 2, 0, 0, 0, -1, 0, 2, 1});

    // ADC strobe while idle must be ignored.
    clear_mon();
    @(negedge clk_i);
    done_f = 1'b1; data_f = 12'hABC;
    @(negedge clk_i);
    done_f = 1'b0;
    repeat (5) @(negedge clk_i);
    chk("idle_strobe_valid", v_row.size(), 0);
    chk("idle_strobe_busy", busy_o, 0);
    chk("idle_strobe_data", data_o, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_nxm_scan_ctrl
